// File: rtl/de2_115_qsys_key_debounce_pio.sv
// de2_115_qsys_key_debounce_pio
// Purpose : Avalon-MM PIO for mechanical keys. Each input is synchronised,
//           debounced and edge-detected, and a sticky edge-capture register
//           drives a maskable interrupt.
// Latency : stable updates max(DEBOUNCE_CYCLES,1)+1 edges after the pin is
//           first sampled, and capture sets one edge later. readdata is
//           registered, so a read returns data one cycle after the address.
// Backpressure: none; the slave never stalls, and reads and writes complete
//           in a single cycle.
// Ports   : clk/reset_n      clock and asynchronous active-low reset
//           address          word address (0 stable, 1 raw, 2 irq_mask,
//                            3 edge_capture)
//           chipselect/write_n/writedata  Avalon-MM write strobe and data
//           in_port          asynchronous key inputs
//           readdata         registered read data
//           irq              interrupt request, |(edge_capture & irq_mask)
module de2_115_qsys_key_debounce_pio #(
   parameter int unsigned      WIDTH           = 4,
   parameter int unsigned      DEBOUNCE_CYCLES = 50000,
   parameter int unsigned      EDGE_TYPE       = 1,
   parameter int unsigned      BIT_CLEAR       = 1,
   parameter logic [WIDTH-1:0] INIT_LEVEL      = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   // Counter is wide enough to hold DEBOUNCE_CYCLES-1, with a minimum of 1 bit.
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((DEBOUNCE_CYCLES == 0) ? 0 : DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] s1_q, s2_q;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [WIDTH-1:0] prev_q;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [31:0]      readdata_q, readdata_d;

   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] cap_clr;
   logic             mask_wr;
   logic             cap_wr;

   // Only the low WIDTH bits of writedata are meaningful.
   logic             unused_wdata;
   assign unused_wdata = ^writedata;

   assign mask_wr = chipselect & ~write_n & (address == 2'd2);
   assign cap_wr  = chipselect & ~write_n & (address == 2'd3);

   // Per-channel debounce. Any return to the stable level restarts the count,
   // so a glitch shorter than DEBOUNCE_CYCLES cycles never propagates.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (DEBOUNCE_CYCLES == 0) begin
            stable_d[i] = s2_q[i];
         end else if (s2_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            stable_d[i] = s2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_comb begin
      if (EDGE_TYPE == 0) begin
         edge_det = stable_q & ~prev_q;
      end else if (EDGE_TYPE == 1) begin
         edge_det = ~stable_q & prev_q;
      end else begin
         edge_det = stable_q ^ prev_q;
      end
   end

   // The clear is applied first and the new edge is ORed in afterwards, so an
   // edge arriving in the same cycle as its clear is not lost.
   always_comb begin
      cap_clr = '0;
      if (cap_wr) begin
         cap_clr = (BIT_CLEAR != 0) ? writedata[WIDTH-1:0] : {WIDTH{1'b1}};
      end
      edge_capture_d = (edge_capture_q & ~cap_clr) | edge_det;
   end

   always_comb begin
      irq_mask_d = irq_mask_q;
      if (mask_wr) begin
         irq_mask_d = writedata[WIDTH-1:0];
      end
   end

   always_comb begin
      readdata_d = '0;
      case (address)
         2'd0:    readdata_d[WIDTH-1:0] = stable_q;
         2'd1:    readdata_d[WIDTH-1:0] = s2_q;
         2'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
         default: readdata_d[WIDTH-1:0] = edge_capture_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q           <= INIT_LEVEL;
         s2_q           <= INIT_LEVEL;
         stable_q       <= INIT_LEVEL;
         prev_q         <= INIT_LEVEL;
         edge_capture_q <= '0;
         irq_mask_q     <= '0;
         readdata_q     <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q           <= in_port;
         s2_q           <= s1_q;
         stable_q       <= stable_d;
         prev_q         <= stable_q;
         edge_capture_q <= edge_capture_d;
         irq_mask_q     <= irq_mask_d;
         readdata_q     <= readdata_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign readdata = readdata_q;
   // Built only from flops, so irq cannot glitch on combinational hazards.
   assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_de2_115_qsys_key_debounce_pio.sv
module tb_de2_115_qsys_key_debounce_pio;

   logic        clk;
   logic        reset_n;

   // Instance A: WIDTH=4, DEBOUNCE_CYCLES=4, falling edges, write-1-to-clear
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   // Instance B: WIDTH=4, bypassed debounce, any edge
   logic [1:0]  address2;
   logic        chipselect2;
   logic        write_n2;
   logic [31:0] writedata2;
   logic [3:0]  in_port2;
   logic [31:0] readdata2;
   logic        irq2;

   int n_checks;
   int n_errors;

   de2_115_qsys_key_debounce_pio #(
      .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .BIT_CLEAR(1), .INIT_LEVEL(4'hF)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   de2_115_qsys_key_debounce_pio #(
      .WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .BIT_CLEAR(1), .INIT_LEVEL(4'hF)
   ) dut2 (
      .clk(clk), .reset_n(reset_n), .address(address2), .chipselect(chipselect2),
      .write_n(write_n2), .writedata(writedata2), .in_port(in_port2),
      .readdata(readdata2), .irq(irq2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Single-cycle write on instance A; address stays put afterwards.
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (readdata !== 32'h0) begin
         n_errors++; $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0);
      end
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++; $display("FAIL reset_irq: got %b expected 0", irq);
      end
      n_checks++;
      if (readdata2 !== 32'h0) begin
         n_errors++; $display("FAIL reset_readdata2: got %h expected %h", readdata2, 32'h0);
      end
      tick(2);
      reset_n = 1'b1;
      address = 2'd0;
      tick(1);
      n_checks++;
      if (readdata !== 32'h0000000F) begin
         n_errors++; $display("FAIL reset_stable_read: got %h expected %h", readdata, 32'hF);
      end
   endtask

   task automatic test_debounce_latency();
      bus_write(2'd2, 32'hF);
      in_port = 4'b1110;     // set up before edge k
      address = 2'd0;
      tick(6);               // after edge k+5: readdata shows stable from k+4
      n_checks++;
      if (readdata !== 32'hF) begin
         n_errors++; $display("FAIL latency_stable_early: got %h expected %h", readdata, 32'hF);
      end
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++; $display("FAIL latency_irq_early: got %b expected 0", irq);
      end
      tick(1);               // after edge k+6
      n_checks++;
      if (readdata !== 32'hE) begin
         n_errors++; $display("FAIL latency_stable: got %h expected %h", readdata, 32'hE);
      end
      n_checks++;
      if (irq !== 1'b1) begin
         n_errors++; $display("FAIL latency_irq: got %b expected 1", irq);
      end
      address = 2'd3;
      tick(1);
      n_checks++;
      if (readdata !== 32'h1) begin
         n_errors++; $display("FAIL latency_capture: got %h expected %h", readdata, 32'h1);
      end
   endtask

   task automatic test_glitch();
      bus_write(2'd3, 32'hF);
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++; $display("FAIL glitch_clear_irq: got %b expected 0", irq);
      end
      in_port = 4'b1100;
      tick(3);
      in_port = 4'b1110;
      tick(10);
      address = 2'd0;
      tick(1);
      n_checks++;
      if (readdata !== 32'hE) begin
         n_errors++; $display("FAIL glitch_stable: got %h expected %h", readdata, 32'hE);
      end
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++; $display("FAIL glitch_irq: got %b expected 0", irq);
      end
      address = 2'd3;
      tick(1);
      n_checks++;
      if (readdata !== 32'h0) begin
         n_errors++; $display("FAIL glitch_capture: got %h expected %h", readdata, 32'h0);
      end
      address = 2'd1;
      tick(1);
      n_checks++;
      if (readdata !== 32'hE) begin
         n_errors++; $display("FAIL raw_read: got %h expected %h", readdata, 32'hE);
      end
   endtask

   task automatic test_irq_mask();
      in_port = 4'b1111;     // rising on bit 0: not captured in falling mode
      tick(10);
      in_port = 4'b1100;     // falling on bits 0 and 1
      tick(10);
      address = 2'd3;
      tick(1);
      n_checks++;
      if (readdata !== 32'h3) begin
         n_errors++; $display("FAIL mask_capture_pre: got %h expected %h", readdata, 32'h3);
      end
      bus_write(2'd2, 32'h5);
      tick(1);
      n_checks++;
      if (readdata !== 32'h5) begin
         n_errors++; $display("FAIL mask_read: got %h expected %h", readdata, 32'h5);
      end
      n_checks++;
      if (irq !== 1'b1) begin
         n_errors++; $display("FAIL mask_irq_on: got %b expected 1", irq);
      end
      bus_write(2'd3, 32'h1);
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++; $display("FAIL mask_irq_off: got %b expected 0", irq);
      end
      tick(1);
      n_checks++;
      if (readdata !== 32'h2) begin
         n_errors++; $display("FAIL w1c_capture: got %h expected %h", readdata, 32'h2);
      end
   endtask

   task automatic test_set_wins();
      in_port = 4'b1000;     // falling on bit 2, set up before edge k
      tick(6);               // after edge k+5: bit-2 edge is live
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = 2'd3;
      writedata  = 32'h4;
      @(negedge clk);        // edge k+6: clear and set collide
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      tick(1);
      n_checks++;
      if (readdata !== 32'h6) begin
         n_errors++; $display("FAIL set_wins_capture: got %h expected %h", readdata, 32'h6);
      end
      n_checks++;
      if (irq !== 1'b1) begin
         n_errors++; $display("FAIL set_wins_irq: got %b expected 1", irq);
      end
      bus_write(2'd3, 32'h4);
      tick(1);
      n_checks++;
      if (readdata !== 32'h2) begin
         n_errors++; $display("FAIL clear_after_set: got %h expected %h", readdata, 32'h2);
      end
   endtask

   task automatic test_ignored_writes();
      bus_write(2'd0, 32'h0);
      bus_write(2'd1, 32'h0);
      address = 2'd0;
      tick(1);
      n_checks++;
      if (readdata !== 32'h8) begin
         n_errors++; $display("FAIL ignored_write_stable: got %h expected %h", readdata, 32'h8);
      end
      address = 2'd2;
      tick(1);
      n_checks++;
      if (readdata !== 32'h5) begin
         n_errors++; $display("FAIL ignored_write_mask: got %h expected %h", readdata, 32'h5);
      end
   endtask

   task automatic test_any_edge_bypass();
      chipselect2 = 1'b1; write_n2 = 1'b0; address2 = 2'd2; writedata2 = 32'hF;
      @(negedge clk);
      chipselect2 = 1'b0; write_n2 = 1'b1; address2 = 2'd3; writedata2 = '0;
      in_port2 = 4'b0111;    // first transition before edge k
      tick(3);
      n_checks++;
      if (irq2 !== 1'b0) begin
         n_errors++; $display("FAIL any_fall_early: got %b expected 0", irq2);
      end
      tick(1);               // after edge k+3
      n_checks++;
      if (irq2 !== 1'b1) begin
         n_errors++; $display("FAIL any_fall_set: got %b expected 1", irq2);
      end
      chipselect2 = 1'b1; write_n2 = 1'b0; writedata2 = 32'h8;
      @(negedge clk);        // clear at edge k+4
      chipselect2 = 1'b0; write_n2 = 1'b1; writedata2 = '0;
      n_checks++;
      if (irq2 !== 1'b0) begin
         n_errors++; $display("FAIL any_cleared: got %b expected 0", irq2);
      end
      in_port2 = 4'b1111;    // second transition after 5 cycles low
      tick(3);
      n_checks++;
      if (irq2 !== 1'b0) begin
         n_errors++; $display("FAIL any_rise_early: got %b expected 0", irq2);
      end
      tick(1);
      n_checks++;
      if (irq2 !== 1'b1) begin
         n_errors++; $display("FAIL any_rise_set: got %b expected 1", irq2);
      end
      tick(1);
      n_checks++;
      if (readdata2 !== 32'h8) begin
         n_errors++; $display("FAIL any_capture_read: got %h expected %h", readdata2, 32'h8);
      end
   endtask

   task automatic test_reset_mid_count();
      in_port = 4'b1111;     // bits 0..2 start counting toward high
      tick(3);
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (readdata !== 32'h0) begin
         n_errors++; $display("FAIL midreset_readdata: got %h expected %h", readdata, 32'h0);
      end
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++; $display("FAIL midreset_irq: got %b expected 0", irq);
      end
      @(negedge clk);
      reset_n = 1'b1;
      address = 2'd0;
      tick(2);
      n_checks++;
      if (readdata !== 32'h0000000F) begin
         n_errors++; $display("FAIL midreset_stable: got %h expected %h", readdata, 32'hF);
      end
      address = 2'd2;
      tick(1);
      n_checks++;
      if (readdata !== 32'h0) begin
         n_errors++; $display("FAIL midreset_mask: got %h expected %h", readdata, 32'h0);
      end
      address = 2'd3;
      tick(10);
      n_checks++;
      if (readdata !== 32'h0) begin
         n_errors++; $display("FAIL midreset_capture: got %h expected %h", readdata, 32'h0);
      end
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++; $display("FAIL midreset_irq_after: got %b expected 0", irq);
      end
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      reset_n     = 1'b0;
      address     = 2'd0;
      chipselect  = 1'b0;
      write_n     = 1'b1;
      writedata   = '0;
      in_port     = 4'hF;
      address2    = 2'd0;
      chipselect2 = 1'b0;
      write_n2    = 1'b1;
      writedata2  = '0;
      in_port2    = 4'hF;

      test_reset();
      test_debounce_latency();
      test_glitch();
      test_irq_mask();
      test_set_wins();
      test_ignored_writes();
      test_any_edge_bypass();
      test_reset_mid_count();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/de2_115_qsys_key_debounce_pio.md
DE2_115_QSYS_KEY_DEBOUNCE_PIO -- requirements
Module: de2_115_qsys_key_debounce_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4, channel count (1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, stable cycles required before accepting a level change (0 = bypass).
REQ-003 SHALL have parameter EDGE_TYPE, default 1, capture mode: 0 = rising, 1 = falling, 2 = any.
REQ-004 SHALL have parameter BIT_CLEAR, default 1, edge-capture clear mode: 1 = write-1-to-clear per bit, 0 = any write clears all bits.
REQ-005 SHALL have parameter INIT_LEVEL, default all-ones (WIDTH bits), reset value of the synchroniser, debounced and previous-level registers.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port address, input, 2, Avalon-MM word address.
REQ-009 SHALL have port chipselect, input, 1, slave select.
REQ-010 SHALL have port write_n, input, 1, active-low write strobe.
REQ-011 SHALL have port writedata, input, 32, write data.
REQ-012 SHALL have port in_port, input, WIDTH, asynchronous key inputs.
REQ-013 SHALL have port readdata, output, 32, registered read data.
REQ-014 SHALL have port irq, output, 1, interrupt request.

Function
REQ-015 SHALL pass in_port through a two-flop synchroniser (s1, s2) per bit.
REQ-016 SHALL keep one per-channel counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits, minimum 1 bit.
REQ-017 SHALL debounce each cycle per channel as follows: s2 == stable -> cnt <= 0; otherwise cnt == DEBOUNCE_CYCLES-1 -> stable <= s2 and cnt <= 0; otherwise cnt <= cnt+1.
REQ-018 SHALL, when DEBOUNCE_CYCLES is 0, load stable <= s2 every cycle; counters are unused (timing identical to DEBOUNCE_CYCLES = 1).
REQ-019 SHALL restart a channel's count from 0 on any mismatch interruption (glitch shorter than DEBOUNCE_CYCLES leaves stable unchanged).
REQ-020 SHALL register prev <= stable every cycle and form edge per EDGE_TYPE: rising = stable & ~prev, falling = ~stable & prev, any = stable ^ prev.
REQ-021 SHALL produce latency, for an in_port change set up before edge k and held: stable updates at edge k+1+max(DEBOUNCE_CYCLES,1), and the capture bit sets at the following edge.
REQ-022 SHALL, in edge_capture[i], set to 1 on edge[i] and hold until cleared.
REQ-023 SHALL define a capture write as chipselect & ~write_n & address==3; with BIT_CLEAR=1 it clears the bits where writedata is 1, and with BIT_CLEAR=0 it clears all bits.
REQ-024 SHALL, when a clear and an edge hit the same bit in the same cycle, have the set win and end with the bit at 1.
REQ-025 SHALL write irq_mask <= writedata[WIDTH-1:0] when chipselect & ~write_n & address==2.
REQ-026 SHALL ignore writes to addresses 0 and 1.
REQ-027 SHALL decode reads as address 0 = stable (debounced), 1 = s2 (raw synchronised), 2 = irq_mask, 3 = edge_capture.
REQ-028 SHALL register readdata every clock regardless of chipselect, with 1-cycle latency, zero-extended above WIDTH.
REQ-029 SHALL drive irq = |(edge_capture & irq_mask), combinational from registers and glitch-free.

Reset
REQ-030 SHALL, while reset_n is low, asynchronously set s1, s2, stable and prev to INIT_LEVEL, and cnt, edge_capture, irq_mask and readdata to 0; irq is therefore 0.
REQ-031 SHALL, on reset assertion mid-debounce, discard the pending count; no edge is captured from a level held equal to INIT_LEVEL after release.

Verification
REQ-032 SHALL cover: WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1, in_port 1111->1110 before edge k and held -> stable[0]=0 at edge k+5, edge_capture=0001 at edge k+6.
REQ-033 SHALL cover: same configuration, in_port[1] low for 3 cycles then high -> stable, edge_capture and irq unchanged.
REQ-034 SHALL cover: irq_mask=0101 with edge_capture=0011 -> irq=1; write 0001 to address 3 -> edge_capture=0010 and irq=0 the next cycle.
REQ-035 SHALL cover: a capture write clearing bit 2 in the same cycle bit 2 edge fires -> edge_capture[2]=1 after the edge.
REQ-036 SHALL cover: EDGE_TYPE=2, DEBOUNCE_CYCLES=0, in_port[3] pulses 1->0->1 with each level held for 5 cycles -> capture sets 3 cycles after each transition; clearing between the two transitions shows two separate sets.
REQ-037 SHALL cover: reset_n pulsed low mid-count with in_port=1111 -> all registers at reset values, no capture after release, and a read of address 0 returns 0x0000000F two cycles after release.
